// File: rtl/series_seq_ctrl.sv
// ---------------------------------------------------------------------------
// series_seq_ctrl
//   Sequencing controller for the iterative series-evaluation datapath
//   (x register, term register, result register).
//   This controller owns the iteration counter. It takes a run-time term
//   count and exposes the iteration index, which addresses the coefficient
//   ROM.
//
//   Run sequence:
//     IDLE -> ARM (while start held) -> LOADX -> {TERM, ACC} x N -> DONE -> IDLE
//   When N == 0 the run goes LOADX -> DONE directly.
//
// Parameters
//   CNT_W     width of the counter, n_terms and iter_idx (max N = 2^CNT_W-1)
//
// Ports
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-high reset
//   start     run request, level, press-then-release
//   n_terms   term count, latched while in ARM
//   mul_ack   multiplier result valid (only with SERIES_MUL_WAIT_EN)
//   ready     idle, accepts start
//   busy      run in progress
//   done      one-cycle end-of-run pulse
//   initx/ldx, initt/ldt, initr/ldr   datapath register strobes
//   s         datapath select: 0 = multiply path, 1 = add path
//   iter_idx  current iteration index
//
// Build option
//   SERIES_MUL_WAIT_EN  TERM waits for mul_ack; ldt is then asserted only
//                       in the acknowledged TERM cycle.
// ---------------------------------------------------------------------------
module series_seq_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_terms,
`ifdef SERIES_MUL_WAIT_EN
    input  logic             mul_ack,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             initx,
    output logic             ldx,
    output logic             initt,
    output logic             ldt,
    output logic             initr,
    output logic             ldr,
    output logic             s,
    output logic [CNT_W-1:0] iter_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_LOADX = 3'd2;
    localparam logic [2:0] S_TERM  = 3'd3;
    localparam logic [2:0] S_ACC   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n;
    logic             w_last;
    logic             w_term_go;

    // The terminal compare happens before the increment, so the counter
    // stops at N-1 and never wraps, even when N = 2^CNT_W-1.
    always_comb begin
        w_last = (r_cnt == (r_n - CNT_W'(1)));
    end

`ifdef SERIES_MUL_WAIT_EN
    always_comb begin
        w_term_go = mul_ack;
    end
`else
    always_comb begin
        w_term_go = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_ARM;
                end
                S_ARM: begin
                    // n_terms is re-sampled every ARM cycle, so the value
                    // kept is the one seen in the last ARM cycle.
                    r_cnt <= '0;
                    r_n   <= n_terms;
                    if (!start) r_state <= S_LOADX;
                end
                S_LOADX: begin
                    r_state <= (r_n == '0) ? S_DONE : S_TERM;
                end
                S_TERM: begin
                    if (w_term_go) r_state <= S_ACC;
                end
                S_ACC: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= S_TERM;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are a Moore decode of the state. The exception is ldt, which
    // also depends on mul_ack in the wait build. Because the state register
    // resets asynchronously, the strobes drop as soon as rst is asserted.
    always_comb begin
        ready = (r_state == S_IDLE);
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
        initx = (r_state == S_ARM);
        initt = (r_state == S_ARM);
        initr = (r_state == S_ARM);
        ldx   = (r_state == S_LOADX);
        ldt   = (r_state == S_TERM) && w_term_go;
        ldr   = (r_state == S_ACC);
        s     = (r_state == S_ACC);
        iter_idx = r_cnt;
    end

endmodule

// File: tb/tb_series_seq_ctrl.sv
module tb_series_seq_ctrl;

    localparam int CNT_W = 4;
    localparam int P_IDLE = 0, P_ARM = 1, P_LOADX = 2, P_TERM = 3, P_ACC = 4, P_DONE = 5;

    logic clk = 1'b0;
    logic rst, start, mul_ack;
    logic [CNT_W-1:0] n_terms;
    logic ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s;
    logic [CNT_W-1:0] iter_idx;

    series_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_terms(n_terms),
`ifdef SERIES_MUL_WAIT_EN
        .mul_ack(mul_ack),
`endif
        .ready(ready), .busy(busy), .done(done), .initx(initx), .ldx(ldx),
        .initt(initt), .ldt(ldt), .initr(initr), .ldr(ldr), .s(s),
        .iter_idx(iter_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             st;
        logic [CNT_W-1:0] n;
        logic             ack;
    } stim_t;

    // Per-cycle expected trace: the stimulus, the expected output vector,
    // whether iter_idx is checked, and the phase label.
    stim_t            sq[$];
    logic [13:0]      eq[$];
    bit               cq[$];
    int               pq[$];
    int               errors = 0;
    int               checks = 0;
    int               m_idx  = 0;
    int               m_lat  = 0;
    logic [13:0]      obs;

    // Output vector bits: {ready,busy,done,initx,ldx,initt,ldt,initr,ldr,s,iter_idx}
    function automatic logic [13:0] vec(int ph, int idx, bit ldt_on);
        logic [9:0] f;
        f = '0;
        if (ph == P_IDLE) f[9] = 1'b1; else f[8] = 1'b1;
        case (ph)
            P_ARM:   begin f[6] = 1'b1; f[4] = 1'b1; f[2] = 1'b1; end
            P_LOADX: f[5] = 1'b1;
            P_TERM:  f[3] = ldt_on;
            P_ACC:   begin f[1] = 1'b1; f[0] = 1'b1; end
            P_DONE:  f[7] = 1'b1;
            default: ;
        endcase
        return {f, CNT_W'(idx)};
    endfunction

    function automatic logic [CNT_W-1:0] rn();
        return CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
    endfunction

    task automatic push(int ph, logic st, logic [CNT_W-1:0] n, logic ack, int idx, bit chk, bit ldt_on);
        stim_t x;
        x.st = st; x.n = n; x.ack = ack;
        sq.push_back(x);
        eq.push_back(vec(ph, chk ? idx : 0, ldt_on));
        cq.push_back(chk);
        pq.push_back(ph);
    endtask

    task automatic clear_q();
        sq.delete(); eq.delete(); cq.delete(); pq.delete();
    endtask

    // Reference run. The IDLE cycle raises start. ARM lasts a_cyc cycles,
    // and only the last of them has start low, carrying N. After ARM, start
    // and n_terms are noise. Each TERM is preceded by w wait cycles.
    task automatic build_run(int a_cyc, int n, int wmax, bit fixed_w, bit hold_done);
        int w;
        m_lat = 2;
        push(P_IDLE, 1'b1, rn(), 1'($urandom), m_idx, 1, 0);
        for (int a = 0; a < a_cyc; a++)
            push(P_ARM, (a == a_cyc - 1) ? 1'b0 : 1'b1, (a == a_cyc - 1) ? CNT_W'(n) : rn(),
                 1'($urandom), 0, 0, 0);
        push(P_LOADX, 1'($urandom), rn(), 1'($urandom), 0, 1, 0);
        for (int i = 0; i < n; i++) begin
            w = fixed_w ? wmax : $urandom_range(0, wmax);
            for (int j = 0; j < w; j++) push(P_TERM, 1'($urandom), rn(), 1'b0, i, 1, 0);
            push(P_TERM, 1'($urandom), rn(), 1'b1, i, 1, 1);
            push(P_ACC, 1'($urandom), rn(), 1'($urandom), i, 1, 0);
            m_lat += 2 + w;
        end
        m_idx = (n > 0) ? n - 1 : 0;
        push(P_DONE, hold_done, rn(), 1'($urandom), m_idx, 1, 0);
    endtask

    task automatic drive(input stim_t x, output logic [13:0] o);
        start = x.st; n_terms = x.n; mul_ack = x.ack;
        @(negedge clk);
        o = {ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s, iter_idx};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        obs = {ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s, iter_idx};
        checks++;
        if (obs !== vec(P_IDLE, 0, 0)) begin
            errors++; $display("FAIL reset_async: got %b required %b", obs, vec(P_IDLE, 0, 0));
        end
        @(posedge clk); #1;
        obs = {ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s, iter_idx};
        checks++;
        if (obs !== vec(P_IDLE, 0, 0)) begin
            errors++; $display("FAIL reset_held: got %b required %b", obs, vec(P_IDLE, 0, 0));
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int t0, td;
        t0 = -1; td = -1;
        clear_q();
        build_run(5, 3, 0, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (pq[k] == P_ARM && !sq[k].st) t0 = k;
            if (obs[11]) td = k;
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL basic cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
        checks++;
        if (td - t0 !== 8) begin
            errors++; $display("FAIL basic_latency: got %0d required 8", td - t0);
        end
    endtask

    task automatic test_zero();
        clear_q();
        build_run(2, 0, 0, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL zero cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
    endtask

    task automatic test_full();
        int t0, td, nldr;
        t0 = -1; td = -1; nldr = 0;
        clear_q();
        build_run(1, 15, 0, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (pq[k] == P_ARM && !sq[k].st) t0 = k;
            if (obs[11]) td = k;
            if (obs[5]) nldr++;
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL full cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
        checks++;
        if (td - t0 !== 32 || nldr !== 15) begin
            errors++; $display("FAIL full_len: got lat=%0d ldr=%0d required lat=32 ldr=15", td - t0, nldr);
        end
    endtask

    task automatic test_disturb();
        stim_t x;
        clear_q();
        build_run(3, 2, 0, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            if (pq[k] >= P_LOADX && pq[k] != P_DONE) begin
                x = sq[k]; x.n = CNT_W'(7);
                if (pq[k] == P_ACC) x.st = 1'b1;
                sq[k] = x;
            end
        end
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL disturb cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
    endtask

    // start held through DONE: IDLE must appear once before the next ARM.
    task automatic test_back_to_back();
        clear_q();
        build_run(1, 1, 0, 1, 1);
        build_run(2, 2, 0, 1, 1);
        push(P_IDLE, 1'b0, rn(), 1'b0, m_idx, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL b2b cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
    endtask

    task automatic test_random();
        int wmax;
`ifdef SERIES_MUL_WAIT_EN
        wmax = 3;
`else
        wmax = 0;
`endif
        clear_q();
        for (int r = 0; r < 8; r++)
            build_run($urandom_range(1, 4), $urandom_range(0, 15), wmax, 0, 1'($urandom));
        push(P_IDLE, 1'b0, rn(), 1'b0, m_idx, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL random cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
    endtask

`ifdef SERIES_MUL_WAIT_EN
    task automatic test_mul_wait();
        int t0, td;
        t0 = -1; td = -1;
        clear_q();
        build_run(2, 2, 3, 1, 0);
        for (int k = 0; k < sq.size(); k++) begin
            drive(sq[k], obs);
            if (pq[k] == P_ARM && !sq[k].st) t0 = k;
            if (obs[11]) td = k;
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL mul_wait cyc%0d: got %b required %b", k, obs, eq[k]);
            end
        end
        checks++;
        if (td - t0 !== 12) begin
            errors++; $display("FAIL mul_wait_latency: got %0d required 12", td - t0);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        int k;
        clear_q();
        build_run(2, 5, 0, 1, 0);
        k = 0;
        while (pq[k] != P_TERM) begin
            drive(sq[k], obs);
            if (!cq[k]) obs[3:0] = '0;
            checks++;
            if (obs !== eq[k]) begin
                errors++; $display("FAIL midrun cyc%0d: got %b required %b", k, obs, eq[k]);
            end
            k++;
        end
        start = sq[k].st; n_terms = sq[k].n; mul_ack = sq[k].ack;
        @(negedge clk);
        obs = {ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s, iter_idx};
        checks++;
        if (obs !== eq[k]) begin
            errors++; $display("FAIL midrun_term: got %b required %b", obs, eq[k]);
        end
        #2 rst = 1'b1;
        #1;
        obs = {ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s, iter_idx};
        checks++;
        if (obs !== vec(P_IDLE, 0, 0)) begin
            errors++; $display("FAIL midrun_rst_now: got %b required %b", obs, vec(P_IDLE, 0, 0));
        end
        @(posedge clk); #1;
        obs = {ready, busy, done, initx, ldx, initt, ldt, initr, ldr, s, iter_idx};
        checks++;
        if (obs !== vec(P_IDLE, 0, 0)) begin
            errors++; $display("FAIL midrun_rst_hold: got %b required %b", obs, vec(P_IDLE, 0, 0));
        end
        rst = 1'b0;
        start = 1'b0;
        m_idx = 0;
        drive(sq[0], obs);
        obs[13:0] = obs;
        checks++;
        if (obs !== vec(P_IDLE, 0, 0)) begin
            errors++; $display("FAIL midrun_after: got %b required %b", obs, vec(P_IDLE, 0, 0));
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_terms = '0; mul_ack = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_full();
        test_disturb();
        test_back_to_back();
        test_random();
`ifdef SERIES_MUL_WAIT_EN
        test_mul_wait();
`endif
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
